conv_mac_engine: RTL
====================

Name: conv_mac_engine

Overview:
Parametrised successor to the fixed 3x3 matrix accelerator top. Computes one KERNEL_SIZE x KERNEL_SIZE signed integer convolution window (dot product of weights and pixels) using LANES parallel multipliers, a registered lane adder tree and an accumulator. Weights and pixels stream in over valid/ready interfaces fed by the input buffer, and the result leaves on a valid/ready output. It sits between the aFIFO output and the downstream result consumer.

Parameters:
BIT_LENGTH, 16, signed operand width (weights and pixels)
KERNEL_SIZE, 3, kernel edge; TAPS = KERNEL_SIZE*KERNEL_SIZE
LANES, 3, parallel multipliers, 1..TAPS; BEATS = ceil(TAPS/LANES)
ACC_WIDTH, 2*BIT_LENGTH+clog2(TAPS), internal accumulator width

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst  in  1  synchronous active-high reset
cStart  in  1  start request, sampled only in IDLE
wLoad  in  1  with cStart: 1 = load new weights first, 0 = reuse stored weights
cReady  out  1  high only in IDLE
wValid  in  1  weight beat valid
wReady  out  1  high in LOAD_W
wData  in  LANES*BIT_LENGTH  weight beat; lane i in bits [i*BIT_LENGTH +: BIT_LENGTH]
dValid  in  1  pixel beat valid
dReady  out  1  high in RUN
dData  in  LANES*BIT_LENGTH  pixel beat, same lane packing
sumValid  out  1  finalsum valid
sumReady  in  1  consumer accepts finalsum
finalsum  out  2*BIT_LENGTH  signed convolution result

Behaviour:
- Reset: state IDLE, cReady=1, wReady=0, dReady=0, sumValid=0, finalsum=0, accumulator=0, beat counter=0, pipeline valids=0. Weight registers cleared to 0. Reset wins over every other event, including mid-operation; partial sums discarded.
- Beat mapping: beat b, lane i carries tap b*LANES+i. On the final beat, lanes with tap >= TAPS are ignored (masked to 0) for both weights and pixels.
- IDLE: on cStart=1 -> LOAD_W if wLoad=1, else RUN. Accumulator and beat counter cleared on the transition.
- LOAD_W: wReady=1; each wValid&&wReady stores one beat and increments the counter; after beat BEATS-1 -> RUN with counter=0. wValid low stalls indefinitely.
- RUN: dReady=1; each handshake launches one beat. Stage 1 registers LANES signed products (2*BIT_LENGTH each). Stage 2 registers the sign-extended lane sum. The accumulator adds the stage 2 result, sign-extended to ACC_WIDTH. After beat BEATS-1 is accepted -> DRAIN.
- DRAIN: waits for the pipeline to empty. If the last pixel handshake occurs in cycle N, sumValid=1 and finalsum are driven from cycle N+3. State -> OUT.
- OUT: finalsum and sumValid are held stable until sumValid&&sumReady. In that cycle sumValid drops next cycle and state -> IDLE. Back-to-back: cStart asserted in the first IDLE cycle is accepted.
- Width: finalsum = accumulator[2*BIT_LENGTH-1:0] (two's complement truncation) unless CONV_SATURATE_EN.
- cStart outside IDLE is ignored. wValid outside LOAD_W and dValid outside RUN are ignored; no data is consumed.
- Weights persist across windows until reset or the next LOAD_W.

Optional Feature:
CONV_SATURATE_EN
- Defined: finalsum is the accumulator clamped to [-2^(2*BIT_LENGTH-1), 2^(2*BIT_LENGTH-1)-1]. Latency is unchanged because the clamp is applied in the DRAIN->OUT register.
- Undefined: plain truncation to 2*BIT_LENGTH bits.

Test Plan:
- BIT_LENGTH=8, K=3, LANES=3: load weights all 1, pixels 1..9 over 3 beats -> finalsum=45, sumValid asserted 3 cycles after the last dReady handshake.
- Reuse weights (cStart with wLoad=0) after loading weights -1, pixels all 127 -> finalsum=-1143, with no wReady pulse.
- LANES=4, K=3: 3 beats; final-beat lanes 1..3 driven with 0x7F garbage, weights 2, pixels 1..9 -> finalsum=90 (garbage ignored).
- Backpressure: hold sumReady=0 for 5 cycles -> finalsum/sumValid stable and cReady=0 throughout; accept -> cReady=1 next cycle. Toggle dValid every other cycle -> same result as the unstalled run.
- Weights 127, pixels 127 x9 (BIT_LENGTH=8): with CONV_SATURATE_EN finalsum=32767; without it finalsum=14089.
- Assert Rst for 1 cycle after beat 1 of RUN -> all outputs return to reset values, cReady=1, weights=0; a new window then computes correctly.

Source files
------------

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: streams one KERNEL_SIZE x KERNEL_SIZE signed convolution window
// through LANES parallel multipliers, a registered lane adder tree and an accumulator.
//
// Ports:
//   Clk, Rst           clock, synchronous active-high reset
//   cStart, wLoad      start request (IDLE only); wLoad=1 loads fresh weights first
//   cReady             high only in IDLE
//   wValid/wReady/wData  weight beats (LANES lanes of BIT_LENGTH bits, lane i at i*BIT_LENGTH)
//   dValid/dReady/dData  pixel beats, same lane packing
//   sumValid/sumReady/finalsum  result handshake, finalsum is 2*BIT_LENGTH signed
//
// Optional feature macro: CONV_SATURATE_EN
//   defined   -> finalsum is the accumulator clamped to the 2*BIT_LENGTH signed range
//   undefined -> finalsum is the accumulator truncated to 2*BIT_LENGTH bits
module conv_mac_engine #(
  parameter int unsigned BIT_LENGTH  = 16,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned LANES       = 3,
  parameter int unsigned ACC_WIDTH   = 2 * BIT_LENGTH + $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                cStart,
  input  logic                                wLoad,
  output logic                                cReady,
  input  logic                                wValid,
  output logic                                wReady,
  input  logic [LANES*BIT_LENGTH-1:0]         wData,
  input  logic                                dValid,
  output logic                                dReady,
  input  logic [LANES*BIT_LENGTH-1:0]         dData,
  output logic                                sumValid,
  input  logic                                sumReady,
  output logic signed [2*BIT_LENGTH-1:0]      finalsum
);

  localparam int unsigned TAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned BEATS = (TAPS + LANES - 1) / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW    = 2 * BIT_LENGTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]             beat_cnt;
  logic signed [BIT_LENGTH-1:0] w_q [BEATS][LANES];
  logic signed [PW-1:0]         s1_prod [LANES];
  logic                         s1_valid, s1_last, s2_valid, s2_last;
  logic signed [ACC_WIDTH-1:0]  s2_sum, acc;

  logic                         start_c, w_fire_c, d_fire_c, last_beat_c;
  logic                         lane_en_c [LANES];
  logic signed [BIT_LENGTH-1:0] px_c [LANES];
  logic signed [PW-1:0]         prod_c [LANES];
  logic signed [ACC_WIDTH-1:0]  lane_sum_c, acc_nxt_c;
  logic signed [PW-1:0]         result_c;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    w_fire_c  = 1'b0;
    d_fire_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cStart) begin
          start_c   = 1'b1;
          state_nxt = wLoad ? S_LOAD_W : S_RUN;
        end
      end
      S_LOAD_W: begin
        if (wValid) begin
          w_fire_c = 1'b1;
          if (last_beat_c) state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (dValid) begin
          d_fire_c = 1'b1;
          if (last_beat_c) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (s2_valid && s2_last) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (sumReady) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign last_beat_c = (beat_cnt == LAST_BEAT);

  // Lane masking, stage-1 products, stage-2 lane sum, accumulate
  always_comb begin
    lane_sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      // lanes past the last tap on the final beat carry don't-care data
      lane_en_c[i] = ((LANES * 32'(beat_cnt)) + i) < TAPS;
      px_c[i]      = lane_en_c[i] ? $signed(dData[i*BIT_LENGTH +: BIT_LENGTH]) : '0;
      prod_c[i]    = PW'(w_q[beat_cnt][i]) * PW'(px_c[i]);
      lane_sum_c   = lane_sum_c + ACC_WIDTH'(s1_prod[i]);
    end
    acc_nxt_c = acc + s2_sum;
  end

  // Result formatting applied on the DRAIN->OUT capture
  always_comb begin
`ifdef CONV_SATURATE_EN
    result_c = acc_nxt_c[PW-1:0];
    // overflow when the bits above the result sign bit are not a pure sign extension
    if ((|acc_nxt_c[ACC_WIDTH-1:PW-1]) && !(&acc_nxt_c[ACC_WIDTH-1:PW-1])) begin
      result_c = acc_nxt_c[ACC_WIDTH-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    end
`else
    result_c = acc_nxt_c[PW-1:0];
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cReady   <= 1'b1;
      wReady   <= 1'b0;
      dReady   <= 1'b0;
      sumValid <= 1'b0;
      finalsum <= '0;
      beat_cnt <= '0;
      acc      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
      for (int unsigned b = 0; b < BEATS; b++) begin
        for (int unsigned i = 0; i < LANES; i++) w_q[b][i] <= '0;
      end
      for (int unsigned i = 0; i < LANES; i++) s1_prod[i] <= '0;
    end else begin
      cReady <= (state_nxt == S_IDLE);
      wReady <= (state_nxt == S_LOAD_W);
      dReady <= (state_nxt == S_RUN);

      if (start_c)                    beat_cnt <= '0;
      else if (w_fire_c || d_fire_c)  beat_cnt <= last_beat_c ? '0 : beat_cnt + 1'b1;

      if (w_fire_c) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          w_q[beat_cnt][i] <= lane_en_c[i] ? $signed(wData[i*BIT_LENGTH +: BIT_LENGTH]) : '0;
        end
      end

      s1_valid <= d_fire_c;
      s1_last  <= d_fire_c && last_beat_c;
      if (d_fire_c) begin
        for (int unsigned i = 0; i < LANES; i++) s1_prod[i] <= prod_c[i];
      end

      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) s2_sum <= lane_sum_c;

      if (start_c)       acc <= '0;
      else if (s2_valid) acc <= acc_nxt_c;

      if (s2_valid && s2_last) begin
        sumValid <= 1'b1;
        finalsum <= result_c;
      end else if ((state == S_OUT) && sumReady) begin
        sumValid <= 1'b0;
      end
    end
  end

endmodule
